// File: rtl/sequential_gain_mixer_pkg.sv
// Shared types and helpers for the sequential gain mixer: FSM encoding,
// Q-format gain helpers and a runtime ceil-log2 used for auto normalisation.
package sequential_gain_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } state_t;

  // Gain value representing 1.0 in Q1.(gain_bits-1)
  function automatic int unsigned unity_gain(input int unsigned gain_bits);
    return 32'd1 << (gain_bits - 1);
  endfunction

  // Right shift that removes the fractional gain bits
  function automatic int unsigned frac_shift(input int unsigned gain_bits);
    return gain_bits - 1;
  endfunction

  // Ceil-log2 of a runtime value, with 0 and 1 both mapping to 0
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sequential_gain_mixer_if.sv
// Frame request / mixed-result bundle between a frame source and the mixer.
interface sequential_gain_mixer_if #(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned CHANNELS  = 12,
  parameter int unsigned GAIN_BITS = 8
);
  logic                          sample_strobe;
  logic [CHANNELS*DATA_BITS-1:0] din;
  logic [CHANNELS*GAIN_BITS-1:0] gain;
  logic [CHANNELS-1:0]           channel_enable;
  logic signed [DATA_BITS-1:0]   dout;
  logic                          dout_valid;
  logic                          busy;
  logic                          overrun;

  modport master (
    output sample_strobe, din, gain, channel_enable,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, din, gain, channel_enable,
    output dout, dout_valid, busy, overrun
  );
endinterface

// File: rtl/sequential_gain_mixer_signed_saturate.sv
// Combinational clamp of a wide signed value into a narrower signed range.
module signed_saturate #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  value,
  output logic signed [OUT_W-1:0] result_c
);
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    result_c = value[OUT_W-1:0];
    if (value > MAX_V)      result_c = MAX_V[OUT_W-1:0];
    else if (value < MIN_V) result_c = MIN_V[OUT_W-1:0];
  end
endmodule

// File: rtl/sequential_gain_mixer.sv
// Time-multiplexed gain mixer: one MAC per channel per cycle, then scale/saturate.
// Define SEQUENTIAL_GAIN_MIXER_AUTO_NORM_EN to normalise by the enabled-channel count.
module sequential_gain_mixer
  import sequential_gain_mixer_pkg::*;
#(
  parameter int unsigned DATA_BITS = 12,
  parameter int unsigned CHANNELS  = 12,
  parameter int unsigned GAIN_BITS = 8
) (
  input logic                    clk,
  input logic                    rst,
  sequential_gain_mixer_if.slave bus
);
  localparam int unsigned ACC_W   = DATA_BITS + GAIN_BITS + $clog2(CHANNELS) + 1;
  localparam int unsigned PROD_W  = DATA_BITS + GAIN_BITS + 1;
  localparam int unsigned IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SHIFT_W = 8;

  state_t state, state_nx;
  logic   capture_c, accum_c, scale_c;

  logic [CHANNELS*DATA_BITS-1:0] din_q;
  logic [CHANNELS*GAIN_BITS-1:0] gain_q;
  logic [CHANNELS-1:0]           en_q;
  logic signed [ACC_W-1:0]       acc;
  logic [IDX_W-1:0]              idx;
  logic signed [DATA_BITS-1:0]   dout_q;
  logic                          dout_valid_q, busy_q, overrun_q;

  logic signed [DATA_BITS-1:0]   din_ch  [CHANNELS];
  logic [GAIN_BITS-1:0]          gain_ch [CHANNELS];
  logic signed [PROD_W-1:0]      prod_c;
  logic [SHIFT_W-1:0]            shamt_c;
  logic signed [ACC_W-1:0]       scaled_c;
  logic signed [DATA_BITS-1:0]   sat_c;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_unpack
    assign din_ch[n]  = din_q[n*DATA_BITS +: DATA_BITS];
    assign gain_ch[n] = gain_q[n*GAIN_BITS +: GAIN_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    capture_c = 1'b0;
    accum_c   = 1'b0;
    scale_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.sample_strobe) begin
          capture_c = 1'b1;
          state_nx  = ACCUM;
        end
      end
      ACCUM: begin
        accum_c = 1'b1;
        if (idx == IDX_W'(CHANNELS - 1)) state_nx = SCALE;
      end
      SCALE: begin
        scale_c  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gain is zero-extended so it acts as a non-negative signed operand
  assign prod_c = PROD_W'(din_ch[idx]) * PROD_W'($signed({1'b0, gain_ch[idx]}));

`ifdef SEQUENTIAL_GAIN_MIXER_AUTO_NORM_EN
  localparam int unsigned CNT_W = $clog2(CHANNELS + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (capture_c)              cnt <= '0;
    else if (accum_c && en_q[idx])   cnt <= cnt + CNT_W'(1);
  end

  assign shamt_c = SHIFT_W'(frac_shift(GAIN_BITS) + clog2_u(32'(cnt)));
`else
  assign shamt_c = SHIFT_W'(frac_shift(GAIN_BITS) + $clog2(CHANNELS));
`endif

  assign scaled_c = acc >>> shamt_c;

  signed_saturate #(.IN_W(ACC_W), .OUT_W(DATA_BITS)) u_sat (
    .value    (scaled_c),
    .result_c (sat_c)
  );

  // Frame capture, accumulation and result/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q        <= '0;
      gain_q       <= '0;
      en_q         <= '0;
      acc          <= '0;
      idx          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      busy_q       <= (state_nx != IDLE);
      if (bus.sample_strobe && state != IDLE) overrun_q <= 1'b1;
      if (capture_c) begin
        din_q  <= bus.din;
        gain_q <= bus.gain;
        en_q   <= bus.channel_enable;
        acc    <= '0;
        idx    <= '0;
      end
      if (accum_c) begin
        if (en_q[idx]) acc <= acc + ACC_W'(prod_c);
        idx <= idx + IDX_W'(1);
      end
      if (scale_c) begin
        dout_q       <= sat_c;
        dout_valid_q <= 1'b1;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/sequential_gain_mixer.md
SEQUENTIAL_GAIN_MIXER -- requirements
Module: sequential_gain_mixer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, the signed sample width of every input and of the output.
REQ-002 SHALL have parameter CHANNELS, default 12, the number of input channels (legal range 1..64).
REQ-003 SHALL have parameter GAIN_BITS, default 8, the unsigned per-channel gain width in Q1.(GAIN_BITS-1); 2**(GAIN_BITS-1) is unity.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port sample_strobe  in  1  request to mix one frame.
REQ-007 SHALL have port din  in  CHANNELS*DATA_BITS  signed samples; channel n at bits [n*DATA_BITS +: DATA_BITS].
REQ-008 SHALL have port gain  in  CHANNELS*GAIN_BITS  unsigned gains; channel n at [n*GAIN_BITS +: GAIN_BITS].
REQ-009 SHALL have port channel_enable  in  CHANNELS  per-channel enable; 0 means the channel contributes nothing.
REQ-010 SHALL have port dout  out  DATA_BITS  signed mixed sample, held until the next result.
REQ-011 SHALL have port dout_valid  out  1  one-cycle pulse marking a new dout.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port overrun  out  1  sticky flag, strobe arrived while busy.

Function
REQ-014 SHALL implement states IDLE, ACCUM and SCALE.
REQ-015 In IDLE, sample_strobe=1 SHALL capture din, gain and channel_enable into internal registers, clear the accumulator, the channel index and the enabled-count, and enter ACCUM.
REQ-016 ACCUM SHALL process exactly one channel per cycle, index 0 to CHANNELS-1; if enabled: acc += din_n * {1'b0,gain_n} (full-precision signed product) and enabled-count += 1.
REQ-017 The accumulator SHALL be DATA_BITS+GAIN_BITS+clog2(CHANNELS)+1 bits wide and never overflow.
REQ-018 After channel CHANNELS-1, the FSM SHALL enter SCALE; SCALE SHALL compute acc >>> (GAIN_BITS-1+norm_shift) (arithmetic, floor), saturate to [-(2**(DATA_BITS-1)), 2**(DATA_BITS-1)-1], register it to dout, pulse dout_valid and return to IDLE.
REQ-019 Latency: strobe sampled at edge T SHALL give dout_valid=1 in the cycle after edge T+CHANNELS+1; one frame per CHANNELS+2 cycles maximum.
REQ-020 A strobe in the same cycle dout_valid is high SHALL be accepted (FSM is IDLE).
REQ-021 A strobe while busy SHALL be ignored, SHALL set overrun, and SHALL NOT disturb the frame in flight.
REQ-022 Zero enabled channels SHALL produce dout=0 with a normal dout_valid pulse.
REQ-023 Inputs SHALL be sampled only at capture; changes during ACCUM/SCALE SHALL have no effect.

Reset
REQ-024 rst SHALL force IDLE and dout=0, dout_valid=0, busy=0, overrun=0, accumulator, index and count=0, from any state including mid-ACCUM; the aborted frame produces no output.
REQ-025 rst SHALL take priority over a simultaneous sample_strobe.

Configuration
REQ-026 Macro SEQUENTIAL_GAIN_MIXER_AUTO_NORM_EN defined: norm_shift = clog2(enabled-count) (1->0, 2->1, 3..4->2, ...; 0 -> 0).
REQ-027 Macro undefined: norm_shift = clog2(CHANNELS), constant, independent of enables; enabled-count logic may be removed.

Structure
REQ-028 The shared package sequential_gain_mixer_pkg SHALL hold the state encoding and unity-gain/shift helper constants.
REQ-029 Saturation SHALL live in a sub-module signed_saturate (parameterised in/out widths, combinational).

Verification (DATA_BITS=12, CHANNELS=4, GAIN_BITS=8)
REQ-030 All enabled, gains 128, din 100,200,300,400, strobe at T -> dout=250, dout_valid only in the cycle after edge T+5, busy high during T+1..T+5.
REQ-031 All enabled, din 2047, gains 255 -> dout=2047; din -2048, gains 255 -> dout=-2048.
REQ-032 Only ch0 enabled, din 1000, gain 128 -> dout=1000 with AUTO_NORM_EN, 250 without.
REQ-033 channel_enable=0 -> dout=0, dout_valid pulses at normal latency.
REQ-034 Strobe at T then at T+2 -> second ignored, overrun=1 until rst, dout from first frame only.
REQ-035 rst at T+2 of a frame, new strobe afterwards -> no output from aborted frame, all outputs 0 after rst, next frame correct.
